// File: rtl/uart_pkg.sv
// uart_pkg: parity mode encodings, RX state enum and shared parity function
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_PAR  = 2'd2
    } rx_state_e;

    // Words up to 16 bits; zero-extension does not change the XOR reduction
    function automatic logic parity_of(input logic [15:0] d, input logic [1:0] mode);
        return (mode == PAR_EVEN) ? ^d :
               (mode == PAR_ODD)  ? ~^d :
               (mode == PAR_MARK);
    endfunction

endpackage

// File: rtl/parity_gen_chk.sv
// parity_gen_chk: TX parity generator and RX serial frame assembler/parity checker
module parity_gen_chk
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              parity_en,
    input  logic [1:0]        parity_mode,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              busy,
    output logic              tx_parity,
    output logic              tx_parity_vld,
    input  logic              rx_start,
    input  logic              rx_bit,
    input  logic              rx_bit_vld,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_par_err,
    output logic              rx_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              tx_par_q, tx_vld_q;
    logic              accept;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;
    logic [1:0]        mode_q, mode_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    assign accept = tx_load & ~busy;

    // TX: register parity of an accepted load, pulse valid for one cycle
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            tx_par_q <= 1'b0;
            tx_vld_q <= 1'b0;
        end else begin
            tx_par_q <= accept ? (parity_en & parity_of(16'(tx_data), parity_mode)) : tx_par_q;
            tx_vld_q <= accept;
        end
    end

    // RX: state and datapath registers
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // RX: start always restarts the frame; bits shift in LSB-first, then optional parity
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = en_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (rx_start) begin
            state_d = RX_DATA;
            cnt_d   = '0;
            shift_d = '0;
            en_d    = parity_en;
            mode_d  = parity_mode;
        end else begin
            case (state_q)
                RX_DATA: if (rx_bit_vld) begin
                    shift_d = {rx_bit, shift_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = en_q ? RX_PAR : RX_IDLE;
                        data_d  = en_q ? data_q : shift_d;
                        done_d  = ~en_q;
                    end
                end
                RX_PAR: if (rx_bit_vld) begin
                    state_d = RX_IDLE;
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    err_d   = rx_bit != parity_of(16'(shift_q), mode_q);
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign tx_parity     = tx_par_q;
    assign tx_parity_vld = tx_vld_q;
    assign rx_data       = data_q;
    assign rx_done       = done_q;
    assign rx_par_err    = err_q;
    assign rx_busy       = state_q != RX_IDLE;

endmodule

// File: tb/tb_parity_gen_chk.sv
// tb_parity_gen_chk: directed self-checking bench for parity_gen_chk
module tb_parity_gen_chk;

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       parity_en = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy = 1'b0;
    logic       tx_parity, tx_parity_vld;
    logic       rx_start = 1'b0;
    logic       rx_bit = 1'b0;
    logic       rx_bit_vld = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done, rx_par_err, rx_busy;

    int checks = 0;
    int failures = 0;
    int seen_done = 0;

    parity_gen_chk #(.DATA_W(8)) dut (
        .clk1(clk1), .rst(rst), .parity_en(parity_en), .parity_mode(parity_mode),
        .tx_load(tx_load), .tx_data(tx_data), .busy(busy),
        .tx_parity(tx_parity), .tx_parity_vld(tx_parity_vld),
        .rx_start(rx_start), .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld),
        .rx_data(rx_data), .rx_done(rx_done), .rx_par_err(rx_par_err), .rx_busy(rx_busy)
    );

    always #5 clk1 = ~clk1;

    // Drive one TX load; returns at the negedge after the accepting edge
    task automatic tx_once(input logic [7:0] d, input logic en, input logic [1:0] mode);
        tx_data = d; parity_en = en; parity_mode = mode; tx_load = 1'b1;
        @(negedge clk1);
        tx_load = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_bit = b; rx_bit_vld = 1'b1;
        @(negedge clk1);
        rx_bit_vld = 1'b0;
        if (rx_done) seen_done++;
    endtask

    task automatic send_word(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic start_frame(input logic en, input logic [1:0] mode);
        parity_en = en; parity_mode = mode; rx_start = 1'b1;
        @(negedge clk1);
        rx_start = 1'b0;
        if (rx_done) seen_done++;
    endtask

    task automatic test_reset_init;
        #12;
        checks++;
        if ({tx_parity, tx_parity_vld, rx_data, rx_done, rx_par_err, rx_busy} !== 13'h0) begin
            failures++;
            $display("FAIL reset_init outputs=%h required=0", {tx_parity, tx_parity_vld, rx_data, rx_done, rx_par_err, rx_busy});
        end
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
    endtask

    task automatic test_tx_modes;
        logic [7:0] d [6]   = '{8'hA5, 8'hA5, 8'h07, 8'hA5, 8'hA5, 8'hA5};
        logic       en [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] md [6]  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        logic       exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tx_once(d[i], en[i], md[i]);
            checks++;
            if (tx_parity !== exp[i] || tx_parity_vld !== 1'b1) begin
                failures++;
                $display("FAIL tx_mode[%0d] parity=%b vld=%b required parity=%b vld=1", i, tx_parity, tx_parity_vld, exp[i]);
            end
            @(negedge clk1);
            checks++;
            if (tx_parity_vld !== 1'b0 || tx_parity !== exp[i]) begin
                failures++;
                $display("FAIL tx_vld_width[%0d] vld=%b parity=%b required vld=0 parity=%b", i, tx_parity_vld, tx_parity, exp[i]);
            end
        end
    endtask

    task automatic test_tx_gating;
        tx_once(8'h07, 1'b1, 2'b00);
        @(negedge clk1);
        busy = 1'b1;
        tx_once(8'h00, 1'b1, 2'b00);
        checks++;
        if (tx_parity_vld !== 1'b0 || tx_parity !== 1'b1) begin
            failures++;
            $display("FAIL tx_busy vld=%b parity=%b required vld=0 parity=1", tx_parity_vld, tx_parity);
        end
        busy = 1'b0;
        @(negedge clk1);
    endtask

    task automatic test_back_to_back;
        tx_data = 8'h01; parity_en = 1'b1; parity_mode = 2'b00; tx_load = 1'b1;
        @(negedge clk1);
        tx_data = 8'h03;
        checks++;
        if (tx_parity !== 1'b1 || tx_parity_vld !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first parity=%b vld=%b required parity=1 vld=1", tx_parity, tx_parity_vld);
        end
        @(negedge clk1);
        tx_load = 1'b0;
        checks++;
        if (tx_parity !== 1'b0 || tx_parity_vld !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second parity=%b vld=%b required parity=0 vld=1", tx_parity, tx_parity_vld);
        end
        @(negedge clk1);
        checks++;
        if (tx_parity_vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end vld=%b required 0", tx_parity_vld);
        end
    endtask

    task automatic test_rx_even;
        logic perr [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            seen_done = 0;
            start_frame(1'b1, 2'b00);
            send_word(8'h5A, 8);
            checks++;
            if (rx_busy !== 1'b1 || seen_done !== 0) begin
                failures++;
                $display("FAIL rx_even_mid[%0d] busy=%b done_count=%0d required busy=1 done_count=0", k, rx_busy, seen_done);
            end
            send_bit(perr[k]);
            checks++;
            if (rx_done !== 1'b1 || rx_data !== 8'h5A || rx_par_err !== perr[k]) begin
                failures++;
                $display("FAIL rx_even[%0d] done=%b data=%h err=%b required done=1 data=5a err=%b", k, rx_done, rx_data, rx_par_err, perr[k]);
            end
            @(negedge clk1);
            checks++;
            if (rx_done !== 1'b0 || rx_par_err !== 1'b0 || rx_busy !== 1'b0 || rx_data !== 8'h5A) begin
                failures++;
                $display("FAIL rx_even_after[%0d] done=%b err=%b busy=%b data=%h required 0 0 0 5a", k, rx_done, rx_par_err, rx_busy, rx_data);
            end
        end
    endtask

    task automatic test_rx_noparity;
        seen_done = 0;
        start_frame(1'b0, 2'b01);
        send_word(8'hFF, 8);
        checks++;
        if (rx_done !== 1'b1 || rx_data !== 8'hFF || rx_par_err !== 1'b0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rx_noparity done=%b data=%h err=%b busy=%b required 1 ff 0 0", rx_done, rx_data, rx_par_err, rx_busy);
        end
        @(negedge clk1);
    endtask

    task automatic test_rx_idle_bit;
        seen_done = 0;
        send_bit(1'b1);
        @(negedge clk1);
        checks++;
        if (rx_busy !== 1'b0 || seen_done !== 0 || rx_done !== 1'b0) begin
            failures++;
            $display("FAIL rx_idle_bit busy=%b done_count=%0d required busy=0 done_count=0", rx_busy, seen_done);
        end
    endtask

    task automatic test_rx_restart;
        seen_done = 0;
        start_frame(1'b1, 2'b01);
        send_word(8'h07, 3);
        start_frame(1'b1, 2'b01);
        parity_mode = 2'b00;
        send_word(8'h3C, 8);
        send_bit(1'b1);
        checks++;
        if (rx_done !== 1'b1 || rx_data !== 8'h3C || rx_par_err !== 1'b0 || seen_done !== 1) begin
            failures++;
            $display("FAIL rx_restart done=%b data=%h err=%b done_count=%0d required 1 3c 0 1", rx_done, rx_data, rx_par_err, seen_done);
        end
        @(negedge clk1);
    endtask

    task automatic test_rx_start_with_bit;
        seen_done = 0;
        start_frame(1'b1, 2'b00);
        send_word(8'h03, 2);
        rx_start = 1'b1; rx_bit = 1'b1; rx_bit_vld = 1'b1;
        @(negedge clk1);
        rx_start = 1'b0; rx_bit_vld = 1'b0;
        send_word(8'h81, 8);
        send_bit(1'b0);
        checks++;
        if (rx_done !== 1'b1 || rx_data !== 8'h81 || rx_par_err !== 1'b0 || seen_done !== 1) begin
            failures++;
            $display("FAIL rx_start_bit done=%b data=%h err=%b done_count=%0d required 1 81 0 1", rx_done, rx_data, rx_par_err, seen_done);
        end
        @(negedge clk1);
    endtask

    task automatic test_reset_midframe;
        tx_once(8'h07, 1'b1, 2'b00);
        start_frame(1'b1, 2'b00);
        send_word(8'h05, 3);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tx_parity, tx_parity_vld, rx_data, rx_done, rx_par_err, rx_busy} !== 13'h0) begin
            failures++;
            $display("FAIL reset_mid outputs=%h required=0", {tx_parity, tx_parity_vld, rx_data, rx_done, rx_par_err, rx_busy});
        end
        @(negedge clk1);
        rst = 1'b1;
        seen_done = 0;
        @(negedge clk1);
        start_frame(1'b1, 2'b00);
        send_word(8'h5A, 8);
        send_bit(1'b0);
        checks++;
        if (rx_done !== 1'b1 || rx_data !== 8'h5A || rx_par_err !== 1'b0 || seen_done !== 1) begin
            failures++;
            $display("FAIL reset_recover done=%b data=%h err=%b done_count=%0d required 1 5a 0 1", rx_done, rx_data, rx_par_err, seen_done);
        end
        @(negedge clk1);
    endtask

    initial begin
        test_reset_init;
        test_tx_modes;
        test_tx_gating;
        test_back_to_back;
        test_rx_even;
        test_rx_noparity;
        test_rx_idle_bit;
        test_rx_restart;
        test_rx_start_with_bit;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
